// File: rtl/rd_check_pkg.sv
// Shared types and constants for the AXIS read-data checker.
package rd_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int THR_W = 4;

  // Sliced down to the counter width by the users.
  localparam logic [63:0] FIRST_ERR_NONE = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Count register; clear has priority over increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/axis_rd_checker.sv
// AXIS sink that consumes a programmed number of beats, checks them against an
// incrementing pattern and measures first-to-last accept cycles.
module axis_rd_checker
  import rd_check_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  input  logic                    START_REG,
  input  logic [CNT_WIDTH-1:0]    NBEATS_REG,
  input  logic [DATA_WIDTH-1:0]   SEED_REG,
  input  logic                    CHECK_EN_REG,
  input  logic [THR_W-1:0]        THROTTLE_REG,
  output logic                    BUSY_REG,
  output logic                    DONE_REG,
  output logic [CNT_WIDTH-1:0]    BEATS_REG,
  output logic [CNT_WIDTH-1:0]    CYCLES_REG,
  output logic [CNT_WIDTH-1:0]    ERR_CNT_REG,
  output logic [CNT_WIDTH-1:0]    FIRST_ERR_IDX_REG
);

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  ERR_NONE = FIRST_ERR_NONE[CNT_WIDTH-1:0];
  localparam logic [THR_W-1:0]      THR_ONE  = {{(THR_W-1){1'b0}}, 1'b1};

  state_t                state, next_state;
  logic [CNT_WIDTH-1:0]  nbeats;
  logic [CNT_WIDTH-1:0]  beats;
  logic [CNT_WIDTH-1:0]  first_err;
  logic [DATA_WIDTH-1:0] expected;
  logic                  check_en;
  logic [THR_W-1:0]      throttle;
  logic [THR_W-1:0]      thr_cnt, next_thr;
  logic                  ready, busy, done;
  logic                  accept, last_beat, load, cyc_inc, err_inc;

  // Strobe and last are driven constant upstream and carry no information here.
  logic unused_ok;
  assign unused_ok = &{1'b0, s_axis_tstrb, s_axis_tlast};

  assign load      = (state == ST_LOAD);
  assign accept    = s_axis_tvalid & ready & (state == ST_RUN);
  assign last_beat = ((beats + CNT_ONE) == nbeats);
  // Cycle count starts on the first accept and then runs every RUN cycle.
  assign cyc_inc   = accept | ((state == ST_RUN) & (beats != '0));
  assign err_inc   = accept & check_en & (s_axis_tdata != expected);

  // Next-state and next throttle-count logic.
  always_comb begin
    next_state = state;
    next_thr   = thr_cnt;
    case (state)
      ST_IDLE: begin
        if (START_REG) next_state = ST_LOAD;
        else           next_state = ST_IDLE;
      end
      ST_LOAD: begin
        if (NBEATS_REG == '0) next_state = ST_DONE;
        else                  next_state = ST_RUN;
      end
      ST_RUN: begin
        if (accept && last_beat) next_state = ST_DONE;
        else                     next_state = ST_RUN;
      end
      ST_DONE: begin
        if (!START_REG) next_state = ST_IDLE;
        else            next_state = ST_DONE;
      end
      default: next_state = ST_IDLE;
    endcase
    if (load) begin
      next_thr = '0;
    end else if (accept) begin
      next_thr = throttle;
    end else if (thr_cnt != '0) begin
      next_thr = thr_cnt - THR_ONE;
    end else begin
      next_thr = thr_cnt;
    end
  end

  // State, throttle and registered handshake/status flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      thr_cnt <= '0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= next_state;
      thr_cnt <= next_thr;
      ready   <= (next_state == ST_RUN) && (next_thr == '0);
      busy    <= (next_state == ST_RUN);
      done    <= (next_state == ST_DONE);
    end
  end

  // Run configuration, beat count, expected pattern and first-error index.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nbeats    <= '0;
      check_en  <= 1'b0;
      throttle  <= '0;
      expected  <= '0;
      beats     <= '0;
      first_err <= ERR_NONE;
    end else if (load) begin
      nbeats    <= NBEATS_REG;
      check_en  <= CHECK_EN_REG;
      throttle  <= THROTTLE_REG;
      expected  <= SEED_REG;
      beats     <= '0;
      first_err <= ERR_NONE;
    end else if (accept) begin
      beats    <= beats + CNT_ONE;
      expected <= expected + DATA_ONE;
      if (err_inc && (first_err == ERR_NONE)) first_err <= beats;
      else                                    first_err <= first_err;
    end else begin
      beats     <= beats;
      expected  <= expected;
      first_err <= first_err;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cycles (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (load),
    .inc   (cyc_inc),
    .count (CYCLES_REG)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_errors (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (load),
    .inc   (err_inc),
    .count (ERR_CNT_REG)
  );

  assign s_axis_tready     = ready;
  assign BUSY_REG          = busy;
  assign DONE_REG          = done;
  assign BEATS_REG         = beats;
  assign FIRST_ERR_IDX_REG = first_err;

endmodule

// File: tb/tb_axis_rd_checker.sv
// Directed, table-driven bench for axis_rd_checker with hand-computed results.
module tb_axis_rd_checker;

  localparam int DW = 64;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic [7:0]    tstrb;
  logic          tlast;
  logic          tready;
  logic          START_REG;
  logic [CW-1:0] NBEATS_REG;
  logic [DW-1:0] SEED_REG;
  logic          CHECK_EN_REG;
  logic [3:0]    THROTTLE_REG;
  logic          BUSY_REG, DONE_REG;
  logic [CW-1:0] BEATS_REG, CYCLES_REG, ERR_CNT_REG, FIRST_ERR_IDX_REG;

  always #5 clk = ~clk;

  axis_rd_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .s_axis_tvalid     (tvalid),
    .s_axis_tdata      (tdata),
    .s_axis_tstrb      (tstrb),
    .s_axis_tlast      (tlast),
    .s_axis_tready     (tready),
    .START_REG         (START_REG),
    .NBEATS_REG        (NBEATS_REG),
    .SEED_REG          (SEED_REG),
    .CHECK_EN_REG      (CHECK_EN_REG),
    .THROTTLE_REG      (THROTTLE_REG),
    .BUSY_REG          (BUSY_REG),
    .DONE_REG          (DONE_REG),
    .BEATS_REG         (BEATS_REG),
    .CYCLES_REG        (CYCLES_REG),
    .ERR_CNT_REG       (ERR_CNT_REG),
    .FIRST_ERR_IDX_REG (FIRST_ERR_IDX_REG)
  );

  typedef struct {
    logic [31:0] nbeats;
    logic [63:0] seed;
    logic        check_en;
    logic [3:0]  thr;
    logic        gap;
    int          bad0;
    int          bad1;
    logic [31:0] e_beats;
    logic [31:0] e_cycles;
    logic [31:0] e_err;
    logic [31:0] e_first;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int   k, beat, samp, last_acc, stray, extra_acc;
    logic acc;
    NBEATS_REG   = v.nbeats;
    SEED_REG     = v.seed;
    CHECK_EN_REG = v.check_en;
    THROTTLE_REG = v.thr;
    START_REG    = 1'b1;
    k = 0; beat = 0; samp = 0; last_acc = -1; stray = 0; extra_acc = 0;
    while ((DONE_REG !== 1'b1) && (samp < 300)) begin
      if (BUSY_REG === 1'b1) begin
        tvalid = v.gap ? ((k % 2) == 0) : 1'b1;
        k++;
      end else begin
        tvalid = 1'b1;
      end
      tdata = v.seed + 64'(beat);
      if ((beat == v.bad0) || (beat == v.bad1)) tdata = tdata ^ 64'h1;
      acc = tvalid && (tready === 1'b1);
      if ((tready === 1'b1) && (BUSY_REG !== 1'b1)) stray++;
      step();
      if (acc) begin
        beat++;
        last_acc = samp;
      end
      samp++;
    end
    chk($sformatf("v%0d_done_reached", id), DONE_REG, 1'b1);
    if (v.nbeats == 32'd0) chk($sformatf("v%0d_done_after_load", id), samp, 2);
    else                   chk($sformatf("v%0d_done_latency", id), samp - last_acc, 1);
    // Source keeps offering data in DONE; none of it may be taken.
    for (int i = 0; i < 3; i++) begin
      if (tready === 1'b1) extra_acc++;
      step();
    end
    chk($sformatf("v%0d_accepts_seen", id), beat, v.e_beats);
    chk($sformatf("v%0d_ready_outside_run", id), stray + extra_acc, 0);
    chk($sformatf("v%0d_beats", id), BEATS_REG, v.e_beats);
    chk($sformatf("v%0d_cycles", id), CYCLES_REG, v.e_cycles);
    chk($sformatf("v%0d_err", id), ERR_CNT_REG, v.e_err);
    chk($sformatf("v%0d_first_err", id), FIRST_ERR_IDX_REG, v.e_first);
    START_REG = 1'b0;
    step();
    chk($sformatf("v%0d_done_clear", id), {BUSY_REG, DONE_REG}, 2'b00);
    step();
    chk($sformatf("v%0d_beats_hold", id), BEATS_REG, v.e_beats);
  endtask

  initial begin
    int nb;
    vecs[0] = '{32'd16, 64'h100, 1'b1, 4'd0,  1'b0, -1, -1, 32'd16, 32'd16, 32'd0, 32'hFFFF_FFFF};
    vecs[1] = '{32'd16, 64'h100, 1'b1, 4'd0,  1'b0,  5,  9, 32'd16, 32'd16, 32'd2, 32'd5};
    vecs[2] = '{32'd16, 64'h100, 1'b0, 4'd0,  1'b0,  5,  9, 32'd16, 32'd16, 32'd0, 32'hFFFF_FFFF};
    vecs[3] = '{32'd4,  64'h0,   1'b1, 4'd3,  1'b0, -1, -1, 32'd4,  32'd13, 32'd0, 32'hFFFF_FFFF};
    vecs[4] = '{32'd8,  64'h20,  1'b1, 4'd0,  1'b1, -1, -1, 32'd8,  32'd15, 32'd0, 32'hFFFF_FFFF};
    vecs[5] = '{32'd0,  64'h55,  1'b1, 4'd0,  1'b0, -1, -1, 32'd0,  32'd0,  32'd0, 32'hFFFF_FFFF};
    vecs[6] = '{32'd3,  64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 4'd0, 1'b0, -1, -1, 32'd3, 32'd3, 32'd0, 32'hFFFF_FFFF};
    vecs[7] = '{32'd2,  64'h7,   1'b1, 4'd15, 1'b0,  0, -1, 32'd2,  32'd17, 32'd1, 32'd0};

    rstn = 1'b0; tvalid = 1'b1; tdata = '0; tstrb = 8'hFF; tlast = 1'b0;
    START_REG = 1'b0; NBEATS_REG = '0; SEED_REG = '0; CHECK_EN_REG = 1'b0; THROTTLE_REG = 4'd0;
    step();
    chk("rst_ready", tready, 1'b0);
    chk("rst_busy_done", {BUSY_REG, DONE_REG}, 2'b00);
    chk("rst_counters", {BEATS_REG, CYCLES_REG, ERR_CNT_REG}, 96'd0);
    chk("rst_first_err", FIRST_ERR_IDX_REG, 32'hFFFF_FFFF);
    rstn = 1'b1;
    step();
    step();
    chk("idle_no_ready", tready, 1'b0);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Reset in the middle of a run after three beats.
    NBEATS_REG = 32'd8; SEED_REG = 64'h0; CHECK_EN_REG = 1'b1; THROTTLE_REG = 4'd0;
    START_REG = 1'b1;
    tvalid = 1'b1;
    nb = 0;
    for (int i = 0; i < 40 && nb < 3; i++) begin
      tdata = 64'(nb);
      if (tready === 1'b1) nb++;
      step();
    end
    chk("mid_beats3", BEATS_REG, 32'd3);
    chk("mid_busy", BUSY_REG, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_ready", tready, 1'b0);
    chk("mid_rst_flags", {BUSY_REG, DONE_REG}, 2'b00);
    chk("mid_rst_counters", {BEATS_REG, CYCLES_REG, ERR_CNT_REG}, 96'd0);
    chk("mid_rst_first_err", FIRST_ERR_IDX_REG, 32'hFFFF_FFFF);
    START_REG = 1'b0;
    step();
    step();
    rstn = 1'b1;
    step();
    step();
    chk("post_rst_idle", {tready, BUSY_REG, DONE_REG}, 3'b000);
    chk("post_rst_beats", BEATS_REG, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
